// File: rtl/alu_seq_ctrl_if.sv
// Instruction handshake channel between an instruction source and the
// alu_seq_ctrl sequencer.
//
// Handshake: a transfer happens on a rising clock edge where instr_valid and
// instr_ready are both high. The source holds instr stable while instr_valid
// is high and instr_ready is low. The sink asserts instr_ready only when it
// can take a new word. After a transfer the source may drop instr_valid or
// change instr immediately.
//
// Signals:
//   instr_valid  source -> sink  instr holds an instruction
//   instr_ready  sink -> source  sink can accept this cycle
//   instr        source -> sink  32-bit RISC-V instruction word
interface alu_seq_ctrl_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;

  modport master (
    output instr_valid,
    output instr,
    input  instr_ready
  );

  modport slave (
    input  instr_valid,
    input  instr,
    output instr_ready
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: multi-cycle sequencer for a single-cycle RISC-V ALU.
// It accepts one instruction per handshake and decodes the R-type and I-type
// ALU ops ADD/SUB/AND/OR/ADDI/ANDI/ORI. It drives the ALU controls and the
// register-file ports, then writes the result back.
// Sequence: IDLE -> DECODE -> EXEC -> WB -> IDLE. An unsupported instruction
// goes DECODE -> IDLE with a one-cycle illegal pulse.
//
// Optional feature macro: ALU_SEQ_BEQ_EN
//   When defined, BEQ (opcode 1100011, f3=000) is decoded as SUB and reports
//   branch_valid/branch_taken in WB. When undefined, those ports are absent
//   and BEQ is illegal.
//
// Ports:
//   clk, rst            clock (rising edge), async active-high reset
//   ibus (slave)        instr_valid / instr_ready / instr handshake
//   rs1_addr, rs2_addr  regfile read addresses (instr[19:15], instr[24:20])
//   alu_ctl             ALU op: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB
//   alu_src             1 = ALU second operand is alu_imm
//   alu_imm             sign-extended instr[31:20] (0 for R-type)
//   alu_result          combinational ALU result
//   alu_zero            ALU zero flag (used only for BEQ)
//   rd_addr, rd_we      regfile write address / one-cycle write pulse
//   rd_wdata            registered ALU result
//   done                one-cycle pulse when an instruction retires
//   illegal             one-cycle pulse when an instruction is dropped
//   retired_cnt         retired-instruction counter, wraps silently
//   branch_valid/taken  (ALU_SEQ_BEQ_EN only) BEQ outcome in WB
//   dbg_state           current FSM state (0 IDLE,1 DECODE,2 EXEC,3 WB)
module alu_seq_ctrl #(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  alu_seq_ctrl_if.slave    ibus,
  output logic [RA_W-1:0]  rs1_addr,
  output logic [RA_W-1:0]  rs2_addr,
  output logic [3:0]       alu_ctl,
  output logic             alu_src,
  output logic [XLEN-1:0]  alu_imm,
  input  logic [XLEN-1:0]  alu_result,
  input  logic             alu_zero,
  output logic [RA_W-1:0]  rd_addr,
  output logic             rd_we,
  output logic [XLEN-1:0]  rd_wdata,
  output logic             done,
  output logic             illegal,
  output logic [CNT_W-1:0] retired_cnt,
`ifdef ALU_SEQ_BEQ_EN
  output logic             branch_valid,
  output logic             branch_taken,
`endif
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_WB     = 2'd3
  } state_t;

  localparam logic [3:0] CTL_AND = 4'b0000;
  localparam logic [3:0] CTL_OR  = 4'b0001;
  localparam logic [3:0] CTL_ADD = 4'b0010;
  localparam logic [3:0] CTL_SUB = 4'b0110;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  state_t state;

  // Decode works directly on the incoming word so that the registered
  // controls (and the illegal pulse) are already valid during DECODE.
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic            dec_ok;
  logic            dec_br;
  logic [3:0]      dec_ctl;
  logic            dec_src;
  logic [XLEN-1:0] dec_imm;

  assign opcode = ibus.instr[6:0];
  assign funct3 = ibus.instr[14:12];
  assign funct7 = ibus.instr[31:25];

  always_comb begin
    dec_ok  = 1'b0;
    dec_br  = 1'b0;
    dec_ctl = CTL_AND;
    dec_src = 1'b0;
    dec_imm = '0;
    if (opcode == OP_R) begin
      if (funct3 == 3'b000 && funct7 == 7'b0000000) begin
        dec_ok = 1'b1; dec_ctl = CTL_ADD;
      end else if (funct3 == 3'b000 && funct7 == 7'b0100000) begin
        dec_ok = 1'b1; dec_ctl = CTL_SUB;
      end else if (funct3 == 3'b111 && funct7 == 7'b0000000) begin
        dec_ok = 1'b1; dec_ctl = CTL_AND;
      end else if (funct3 == 3'b110 && funct7 == 7'b0000000) begin
        dec_ok = 1'b1; dec_ctl = CTL_OR;
      end
    end else if (opcode == OP_I) begin
      dec_src = 1'b1;
      dec_imm = {{(XLEN-12){ibus.instr[31]}}, ibus.instr[31:20]};
      if (funct3 == 3'b000) begin
        dec_ok = 1'b1; dec_ctl = CTL_ADD;
      end else if (funct3 == 3'b111) begin
        dec_ok = 1'b1; dec_ctl = CTL_AND;
      end else if (funct3 == 3'b110) begin
        dec_ok = 1'b1; dec_ctl = CTL_OR;
      end
    end
`ifdef ALU_SEQ_BEQ_EN
    else if (opcode == OP_BEQ && funct3 == 3'b000) begin
      dec_ok  = 1'b1;
      dec_br  = 1'b1;
      dec_ctl = CTL_SUB;
    end
`endif
    // An illegal word leaves every ALU control at its neutral value.
    if (!dec_ok) begin
      dec_br  = 1'b0;
      dec_ctl = CTL_AND;
      dec_src = 1'b0;
      dec_imm = '0;
    end
  end

  // Branch bookkeeping only matters when BEQ is supported.
  logic is_br;
`ifdef ALU_SEQ_BEQ_EN
  logic br_q;
  assign is_br = br_q;
`else
  logic unused_beq;
  assign is_br      = 1'b0;
  assign unused_beq = alu_zero ^ dec_br;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= S_IDLE;
      ibus.instr_ready <= 1'b1;
      rs1_addr         <= '0;
      rs2_addr         <= '0;
      alu_ctl          <= CTL_AND;
      alu_src          <= 1'b0;
      alu_imm          <= '0;
      rd_addr          <= '0;
      rd_we            <= 1'b0;
      rd_wdata         <= '0;
      done             <= 1'b0;
      illegal          <= 1'b0;
      retired_cnt      <= '0;
`ifdef ALU_SEQ_BEQ_EN
      br_q             <= 1'b0;
      branch_valid     <= 1'b0;
      branch_taken     <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (ibus.instr_valid && ibus.instr_ready) begin
            state            <= S_DECODE;
            ibus.instr_ready <= 1'b0;
            rs1_addr         <= ibus.instr[19:15];
            rs2_addr         <= ibus.instr[24:20];
            rd_addr          <= ibus.instr[11:7];
            alu_ctl          <= dec_ctl;
            alu_src          <= dec_src;
            alu_imm          <= dec_imm;
            illegal          <= !dec_ok;
`ifdef ALU_SEQ_BEQ_EN
            br_q             <= dec_br;
`endif
          end
        end
        S_DECODE: begin
          illegal <= 1'b0;
          if (illegal) begin
            state            <= S_IDLE;
            ibus.instr_ready <= 1'b1;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          state    <= S_WB;
          rd_wdata <= alu_result;
          // Writes to x0 (and branches) run the full sequence without a write.
          rd_we    <= (rd_addr != '0) && !is_br;
          done     <= 1'b1;
`ifdef ALU_SEQ_BEQ_EN
          branch_valid <= br_q;
          branch_taken <= br_q && alu_zero;
`endif
        end
        S_WB: begin
          state            <= S_IDLE;
          ibus.instr_ready <= 1'b1;
          rd_we            <= 1'b0;
          done             <= 1'b0;
          retired_cnt      <= retired_cnt + CNT_W'(1);
`ifdef ALU_SEQ_BEQ_EN
          branch_valid     <= 1'b0;
          branch_taken     <= 1'b0;
`endif
        end
        default: begin
          state            <= S_IDLE;
          ibus.instr_ready <= 1'b1;
        end
      endcase
    end
  end

  assign dbg_state = state;

endmodule
